// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG output path (packer, FIFO, later UART-out).
package prng_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] DROP_CNT_MAX = 8'hFF;
    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/prng_byte_packer_if.sv
// Byte stream from the packer to the output mux: valid/ready with a combinational head byte.
interface prng_byte_packer_if;
    import prng_pkg::*;

    byte_t byte_out;
    logic  byte_valid;
    logic  byte_ready;

    modport master (output byte_out, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/prng_sync_fifo.sv
// Small synchronous FIFO with explicit occupancy counter and first-word-fall-through read.
module prng_sync_fifo
    import prng_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  byte_t            din,
    output byte_t            dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    assign dout  = mem[rptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // Caller guarantees push only when not full or when popping in the same cycle;
    // in that case wptr==rptr and the head being popped is the slot overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/prng_byte_packer.sv
// Packs the 1-bit PRNG stream LSB-first into bytes, queues them, and counts overflow drops.
module prng_byte_packer
    import prng_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    input  logic                       flush,
    prng_byte_packer_if.master         bus,
    output logic [LVL_W-1:0]           level,
    output logic                       drop_pulse,
    output byte_t                      drop_cnt
);
    // Only the upper 7 bits are ever needed: the 8th bit goes straight into the pushed byte.
    logic [BYTE_W-1:1] sr;
    logic [2:0]        bcnt;
    byte_t             sr_nxt;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;

    assign sr_nxt   = {bit_in, sr};
    assign push_req = bit_valid && (bcnt == 3'd7) && !flush;
    assign pop      = bus.byte_valid && bus.byte_ready && !flush;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;

    assign bus.byte_valid = !empty;

    prng_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (sr_nxt),
        .dout  (bus.byte_out),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            bcnt       <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + 8'd1;
            if (flush) begin
                sr   <= '0;
                bcnt <= '0;
            end else if (bit_valid) begin
                sr   <= sr_nxt[BYTE_W-1:1];
                bcnt <= bcnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_prng_byte_packer.sv
// Directed and randomized bench for prng_byte_packer against a queue-based reference model.
module tb_prng_byte_packer;
    import prng_pkg::*;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             flush;
    logic [LVL_W-1:0] level;
    logic             drop_pulse;
    byte_t            drop_cnt;

    prng_byte_packer_if bus();

    prng_byte_packer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .bus        (bus),
        .level      (level),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    npulse = 0;
    byte_t q[$];
    int    bits[$];
    int    m_cnt = 0;
    bit    m_pulse = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("byte_valid", 32'(bus.byte_valid), 32'(q.size() != 0));
        chk("level", 32'(level), 32'(q.size()));
        if (q.size() != 0) chk("byte_out", 32'(bus.byte_out), 32'(q[0]));
        chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
        if (drop_pulse) npulse++;
    endtask

    // Reference: bits collect into a list; eight of them form a byte (first bit = LSB).
    task automatic model_step(input bit bv, input bit bin, input bit fl, input bit rdy);
        bit    done = 1'b0;
        bit    popped;
        byte_t v = '0;
        popped = (q.size() != 0) && rdy;
        m_pulse = 1'b0;
        if (fl) begin
            bits.delete();
            q.delete();
        end else begin
            if (bv) begin
                bits.push_back(int'(bin));
                if (bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) v[i] = bits[i][0];
                    bits.delete();
                    done = 1'b1;
                end
            end
            if (popped) void'(q.pop_front());
            if (done) begin
                if (q.size() < DEPTH) q.push_back(v);
                else begin
                    m_pulse = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    task automatic step(input bit bv, input bit bin, input bit fl, input bit rdy);
        bit_valid      = bv;
        bit_in         = bin;
        flush          = fl;
        bus.byte_ready = rdy;
        model_step(bv, bin, fl, rdy);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic send_byte(input byte_t v, input bit rdy);
        for (int i = 0; i < 8; i++) step(1'b1, v[i], 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; bus.byte_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete(); bits.delete(); m_cnt = 0; m_pulse = 1'b0;
        check_model();
    endtask

    initial begin
        byte_t pk;
        byte_t fp;
        byte_t aa;
        // Reset / idle
        do_reset();
        chk("rst_valid", 32'(bus.byte_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_byte_out", 32'(bus.byte_out), 32'h00);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);

        // Packing order 1,0,1,1,0,0,0,1 -> 0x8D
        pk = 8'b1000_1101;
        for (int i = 0; i < 7; i++) step(1'b1, pk[i], 1'b0, 1'b0);
        chk("pack_not_yet", 32'(bus.byte_valid), 32'd0);
        step(1'b1, pk[7], 1'b0, 1'b0);
        chk("pack_valid", 32'(bus.byte_valid), 32'd1);
        chk("pack_byte", 32'(bus.byte_out), 32'h8D);
        chk("pack_level", 32'(level), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill and overflow
        do_reset();
        npulse = 0;
        for (int b = 1; b <= 6; b++) send_byte(byte_t'(b), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_head", 32'(bus.byte_out), 32'h01);
        chk("ovf_pulses", 32'(npulse), 32'd2);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        for (int b = 1; b <= 4; b++) begin
            chk("drain", 32'(bus.byte_out), 32'(b));
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("drain_empty", 32'(bus.byte_valid), 32'd0);

        // Full with simultaneous pop
        for (int b = 0; b < 4; b++) send_byte(byte_t'(8'h11 + b), 1'b0);
        fp = 8'h55;
        for (int i = 0; i < 7; i++) step(1'b1, fp[i], 1'b0, 1'b0);
        step(1'b1, fp[7], 1'b0, 1'b1);
        chk("fullpop_pulse", 32'(drop_pulse), 32'd0);
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_cnt", 32'(drop_cnt), 32'd2);
        chk("fullpop_h0", 32'(bus.byte_out), 32'h12); step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fullpop_h1", 32'(bus.byte_out), 32'h13); step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fullpop_h2", 32'(bus.byte_out), 32'h14); step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fullpop_h3", 32'(bus.byte_out), 32'h55); step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fullpop_empty", 32'(bus.byte_valid), 32'd0);

        // Flush mid-byte
        do_reset();
        for (int b = 1; b <= 6; b++) send_byte(byte_t'(b), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_flush_level", 32'(level), 32'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(bus.byte_valid), 32'd0);
        chk("flush_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("flush_no_pulse", 32'(drop_pulse), 32'd0);
        aa = 8'hAA;
        for (int i = 0; i < 8; i++) step(1'b1, aa[i], 1'b0, 1'b0);
        chk("flush_byte", 32'(bus.byte_out), 32'hAA);
        chk("flush_byte_level", 32'(level), 32'd1);

        // Saturation: 4 fill + 300 drops
        do_reset();
        npulse = 0;
        for (int b = 0; b < 304; b++) send_byte(byte_t'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_pulses", 32'(npulse), 32'd300);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);

        // Continuous input with ready held high never drops
        do_reset();
        npulse = 0;
        for (int b = 0; b < 50; b++) send_byte(byte_t'($urandom), 1'b1);
        chk("nodrop_pulses", 32'(npulse), 32'd0);
        chk("nodrop_cnt", 32'(drop_cnt), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 2) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prng_byte_packer.md
Name: prng_byte_packer

Overview:
- Downstream stage of the PRNG core. It consumes the 1-bit-per-cycle random stream and packs bits into bytes.
- Completed bytes are buffered in a small FIFO and presented to the top-level output mux over a valid/ready interface.
- Bytes that complete while the FIFO is full are dropped and counted, so sampling rate vs. generation rate is observable on the pins.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output (derived, not overridden).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  random bit from the PRNG core.
- bit_valid  input  1  bit_in is valid this cycle.
- flush  input  1  synchronous discard of the partial byte and all FIFO contents.
- byte_out  output  8  head-of-FIFO byte.
- byte_valid  output  1  FIFO not empty.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- level  output  LVL_W  FIFO occupancy, 0..DEPTH.
- drop_pulse  output  1  one-cycle pulse when a completed byte is discarded.
- drop_cnt  output  8  saturating count of dropped bytes.

Behaviour:
- Reset (rst=1 at an edge) clears the shift register sr and the bit counter bcnt. It also clears the FIFO pointers, level, drop_cnt and drop_pulse.
- After reset: byte_valid=0, level=0, drop_pulse=0, drop_cnt=0. byte_out is 0x00 (storage is cleared on reset).
- Packing: on bit_valid=1, sr <= {bit_in, sr[7:1]} and bcnt <= bcnt+1 (3-bit, wraps). The first bit of a byte lands in bit 0.
- A byte completes when bit_valid=1 and bcnt==7. The completed value is {bit_in, sr[7:1]}, and a push is requested in that same cycle.
- Push/pop:
  - Pop occurs when byte_valid && byte_ready.
  - Push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves level unchanged.
- Latency: a byte completed at edge N has byte_valid=1 from edge N, i.e. it is visible in the cycle after its last bit was sampled.
- byte_out is a combinational read of the head entry. It is stable while byte_valid=1 and byte_ready=0.
- Overflow: a completed byte with no accepted push is discarded. drop_pulse=1 for exactly the following cycle. drop_cnt increments and saturates at 255 (no wrap).
- Flush:
  - flush=1 clears sr, bcnt, pointers and level next edge.
  - drop_cnt is preserved.
  - flush has priority over a simultaneous bit_valid, push and pop: the bit is ignored, nothing is popped, and no drop is counted.
- bit_valid may be high every cycle; no idle cycles are required between bytes.
- Pointers are log2(DEPTH) bits and wrap naturally. level is kept as an explicit counter, not derived from the pointers.
- With byte_ready held high and input at one byte per 8 cycles, no drop may ever occur.

Decomposition:
- Package prng_pkg: BYTE_W=8, DROP_CNT_MAX=8'hFF, and a byte_t typedef (logic [7:0]).
- One sub-module: prng_sync_fifo (parameter DEPTH; ports push/pop/din/dout/level/full/empty). It is reusable by the later UART-out stage.
- The bit packer and drop accounting stay in the top of prng_byte_packer.

Test Plan:
- Reset/idle: assert rst for 2 cycles, then release -> byte_valid=0, level=0, drop_cnt=0, drop_pulse=0, byte_out=0x00.
- Packing order: bits 1,0,1,1,0,0,0,1 on consecutive cycles with byte_ready=0 -> byte_out=0x8D, level=1, byte_valid=1 from the edge after the 8th bit.
- Fill and overflow (DEPTH=4, byte_ready=0):
  - stream 6 bytes 0x01..0x06 -> level=4 and head 0x01;
  - drop_pulse twice, 1 cycle each;
  - drop_cnt=2;
  - draining yields 0x01,0x02,0x03,0x04.
- Full with simultaneous pop: FIFO full, byte 0x55 completes in the same cycle as a pop -> no drop, level stays 4, 0x55 is the last byte drained.
- Flush mid-byte: 3 bits in, 2 bytes queued, drop_cnt=2; then flush together with bit_valid=1.
  - Immediately after: level=0, drop_cnt still 2.
  - Next 8 bits 0,1,0,1,0,1,0,1 -> byte 0xAA.
- Saturation: force 300 overflow bytes with byte_ready=0 -> drop_cnt=255, no wrap, drop_pulse still pulses per drop.
